// File: rtl/e_bus_pkg.sv
// Shared definitions for the 6809 E-clock bus sequencer.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package e_bus_pkg;

  // Per-bus-cycle phases
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // Default timing, in i_clk cycles
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_WE_DELAY    = 2;
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_TIMEOUT     = 200;
  localparam int DEF_CNT_W       = 8;

  // CPU-side polarity: R/W high means the CPU is reading
  localparam logic RW_READ = 1'b1;

  // Chip enable and buffer direction are driven in every non-idle phase
  function automatic logic in_bus_cycle(input state_e s);
    return s != ST_IDLE;
  endfunction

  // Data actually moves (buffer, OE) only once E is high and through hold
  function automatic logic in_data_phase(input state_e s);
    return (s == ST_ACTIVE) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/e_edge_sync.sv
// Synchronises one asynchronous CPU clock pin and flags its rising/falling edges.
// Latency: STAGES flops to the synchronised level; edge pulses valid for one cycle after that.
// Backpressure: none; the pin is free-running and edges are never held off.
module e_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              dly_q, dly_d;

  // Shift the pin through the synchroniser; keep one extra delayed copy for edge compare
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_async};
    dly_d  = sync_q[STAGES-1];
  end

  // Synchroniser and delay flops, cleared so no edge is seen out of reset
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign o_rise = sync_q[STAGES-1] & ~dly_q;
  assign o_fall = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/e_bus_sequencer.sv
// Sequences one 6809 bus cycle per E period: buffer, SRAM strobes and peripheral enable.
// Latency: SYNC_STAGES+1 i_clk cycles from an E/Q pin edge to the registered outputs.
// Backpressure: none; the CPU cannot be stalled, a stuck cycle is aborted by the watchdog.
module e_bus_sequencer
  import e_bus_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int WE_DELAY    = DEF_WE_DELAY,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_e_clk,
  input  logic i_q_clk,
  input  logic i_rw,
  input  logic i_sel_sram,
  input  logic i_sel_periph,
  output logic o_buf_oe,
  output logic o_buf_dir,
  output logic o_sram_ce_n,
  output logic o_sram_oe_n,
  output logic o_sram_we_n,
  output logic o_periph_en,
  output logic o_busy,
  output logic o_timeout,
  output logic o_decode_err
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] WE_C      = CNT_W'(WE_DELAY);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic e_rise, e_fall, q_rise, q_fall_unused;

  e_edge_sync #(.STAGES(SYNC_STAGES)) u_e_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_e_clk),
    .o_rise  (e_rise),
    .o_fall  (e_fall)
  );

  e_edge_sync #(.STAGES(SYNC_STAGES)) u_q_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_q_clk),
    .o_rise  (q_rise),
    .o_fall  (q_fall_unused)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rw_q, rw_d;
  logic             sram_q, sram_d;
  logic             periph_q, periph_d;
  logic             pend_q, pend_d;
  logic             latch;

  logic buf_oe_q, buf_oe_d;
  logic buf_dir_q, buf_dir_d;
  logic ce_n_q, ce_n_d;
  logic oe_n_q, oe_n_d;
  logic we_n_q, we_n_d;
  logic periph_en_q, periph_en_d;
  logic busy_q, busy_d;
  logic timeout_q, timeout_d;
  logic decode_err_q, decode_err_d;

  // Next state, phase counter, decode latch and the strobes that follow from them
  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    rw_d         = rw_q;
    sram_d       = sram_q;
    periph_d     = periph_q;
    pend_d       = pend_q;
    latch        = 1'b0;
    timeout_d    = 1'b0;
    decode_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (q_rise) begin
          latch   = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (e_rise) begin
          cnt_d   = '0;
          state_d = ST_ACTIVE;
        end else if (cnt_q >= TIMEOUT_C) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        // E fall is checked first so a cycle ending exactly at the limit is not aborted
        if (e_fall) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else if (cnt_q >= TIMEOUT_C) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // A Q rise during hold belongs to the next cycle; remember it until hold ends
        if (q_rise) pend_d = 1'b1;
        if (cnt_q >= HOLD_LAST) begin
          pend_d = 1'b0;
          cnt_d  = '0;
          if (pend_q || q_rise) begin
            latch   = 1'b1;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // SRAM wins a decode conflict; the peripheral access is dropped and flagged
    if (latch) begin
      rw_d         = i_rw;
      sram_d       = i_sel_sram;
      periph_d     = i_sel_periph & ~i_sel_sram;
      decode_err_d = i_sel_sram & i_sel_periph;
    end

    // Outputs are decoded from the next state so every pin comes straight off a flop
    buf_oe_d    = in_data_phase(state_d) & (sram_d | periph_d);
    buf_dir_d   = in_bus_cycle(state_d) & (rw_d == RW_READ);
    ce_n_d      = ~(in_bus_cycle(state_d) & sram_d);
    oe_n_d      = ~(in_data_phase(state_d) & sram_d & (rw_d == RW_READ));
    we_n_d      = ~((state_d == ST_ACTIVE) & sram_d & (rw_d != RW_READ) & (cnt_d >= WE_C));
    periph_en_d = (state_d == ST_ACTIVE) & periph_d;
    busy_d      = in_bus_cycle(state_d);
  end

  // Sequencer state; reset drops every strobe immediately
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rw_q         <= 1'b0;
      sram_q       <= 1'b0;
      periph_q     <= 1'b0;
      pend_q       <= 1'b0;
      buf_oe_q     <= 1'b0;
      buf_dir_q    <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      periph_en_q  <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      decode_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rw_q         <= rw_d;
      sram_q       <= sram_d;
      periph_q     <= periph_d;
      pend_q       <= pend_d;
      buf_oe_q     <= buf_oe_d;
      buf_dir_q    <= buf_dir_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      periph_en_q  <= periph_en_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      decode_err_q <= decode_err_d;
    end
  end

  assign o_buf_oe     = buf_oe_q;
  assign o_buf_dir    = buf_dir_q;
  assign o_sram_ce_n  = ce_n_q;
  assign o_sram_oe_n  = oe_n_q;
  assign o_sram_we_n  = we_n_q;
  assign o_periph_en  = periph_en_q;
  assign o_busy       = busy_q;
  assign o_timeout    = timeout_q;
  assign o_decode_err = decode_err_q;

endmodule

// File: tb/tb_e_bus_sequencer.sv
// Directed bench for the E-clock bus sequencer: table of bus cycles plus multi-cycle corners.
// Latency: inputs change on the falling i_clk edge, outputs are sampled on the falling edge.
// Backpressure: none; every sequence is a fixed-length cycle loop.
module tb_e_bus_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic e_pin = 1'b0, q_pin = 1'b0, rw = 1'b1, sel_sram = 1'b0, sel_periph = 1'b0;
  logic buf_oe, buf_dir, ce_n, oe_n, we_n, periph_en, busy, timeout, decode_err;

  always #5 clk = ~clk;

  e_bus_sequencer dut (
    .i_clk(clk), .i_reset(rst), .i_e_clk(e_pin), .i_q_clk(q_pin), .i_rw(rw),
    .i_sel_sram(sel_sram), .i_sel_periph(sel_periph),
    .o_buf_oe(buf_oe), .o_buf_dir(buf_dir), .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n),
    .o_sram_we_n(we_n), .o_periph_en(periph_en), .o_busy(busy), .o_timeout(timeout),
    .o_decode_err(decode_err)
  );

  // {buf_oe, buf_dir, ce_n, oe_n, we_n, periph_en, busy, timeout, decode_err}
  logic [8:0] outs;
  assign outs = {buf_oe, buf_dir, ce_n, oe_n, we_n, periph_en, busy, timeout, decode_err};

  localparam logic [8:0] IDL     = 9'b001110000;
  localparam logic [8:0] TMO     = 9'b001110010;
  localparam logic [8:0] SR_SET  = 9'b010110100;
  localparam logic [8:0] SR_ACT  = 9'b110010100;
  localparam logic [8:0] SW_SET  = 9'b000110100;
  localparam logic [8:0] SW_ACT0 = 9'b100110100;
  localparam logic [8:0] SW_ACT1 = 9'b100100100;
  localparam logic [8:0] PR_SET  = 9'b011110100;
  localparam logic [8:0] PR_ACT  = 9'b111111100;
  localparam logic [8:0] PR_HLD  = 9'b111110100;
  localparam logic [8:0] PW_SET  = 9'b001110100;
  localparam logic [8:0] PW_ACT  = 9'b101111100;
  localparam logic [8:0] PW_HLD  = 9'b101110100;
  localparam logic [8:0] NT_ALL  = 9'b011110100;

  typedef struct packed {
    logic rw, sram, periph;
    logic [8:0] e02, e03, e04, e27, e28, e29, e30, e77, e78, e81, e82;
  } vec_t;

  vec_t vecs [7];
  int   samp_t [11];
  logic [8:0] cap [0:399];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [8:0] exp_at(input vec_t v, input int k);
    case (k)
      0: return v.e02;  1: return v.e03;  2: return v.e04;  3: return v.e27;
      4: return v.e28;  5: return v.e29;  6: return v.e30;  7: return v.e77;
      8: return v.e78;  9: return v.e81;  default: return v.e82;
    endcase
  endfunction

  // One bus cycle starting at a Q rise on t=0; outputs captured before driving each step
  task automatic run_seq(input int len, input int er, input int ef,
                         input logic r, input logic s, input logic p);
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      cap[t]     = outs;
      q_pin      = (t < 50);
      e_pin      = (t >= er) && (t < ef);
      rw         = r;
      sel_sram   = s;
      sel_periph = p;
    end
  endtask

  initial begin
    int cnt;
    samp_t = '{2, 3, 4, 27, 28, 29, 30, 77, 78, 81, 82};
    vecs[0] = '{rw:1'b1, sram:1'b1, periph:1'b0, e02:IDL, e03:SR_SET, e04:SR_SET, e27:SR_SET,
                e28:SR_ACT, e29:SR_ACT, e30:SR_ACT, e77:SR_ACT, e78:SR_ACT, e81:SR_ACT, e82:IDL};
    vecs[1] = '{rw:1'b0, sram:1'b1, periph:1'b0, e02:IDL, e03:SW_SET, e04:SW_SET, e27:SW_SET,
                e28:SW_ACT0, e29:SW_ACT0, e30:SW_ACT1, e77:SW_ACT1, e78:SW_ACT0, e81:SW_ACT0, e82:IDL};
    vecs[2] = '{rw:1'b1, sram:1'b0, periph:1'b1, e02:IDL, e03:PR_SET, e04:PR_SET, e27:PR_SET,
                e28:PR_ACT, e29:PR_ACT, e30:PR_ACT, e77:PR_ACT, e78:PR_HLD, e81:PR_HLD, e82:IDL};
    vecs[3] = '{rw:1'b0, sram:1'b0, periph:1'b1, e02:IDL, e03:PW_SET, e04:PW_SET, e27:PW_SET,
                e28:PW_ACT, e29:PW_ACT, e30:PW_ACT, e77:PW_ACT, e78:PW_HLD, e81:PW_HLD, e82:IDL};
    vecs[4] = '{rw:1'b1, sram:1'b1, periph:1'b1, e02:IDL, e03:SR_SET | 9'd1, e04:SR_SET, e27:SR_SET,
                e28:SR_ACT, e29:SR_ACT, e30:SR_ACT, e77:SR_ACT, e78:SR_ACT, e81:SR_ACT, e82:IDL};
    vecs[5] = '{rw:1'b1, sram:1'b0, periph:1'b0, e02:IDL, e03:NT_ALL, e04:NT_ALL, e27:NT_ALL,
                e28:NT_ALL, e29:NT_ALL, e30:NT_ALL, e77:NT_ALL, e78:NT_ALL, e81:NT_ALL, e82:IDL};
    vecs[6] = '{rw:1'b0, sram:1'b1, periph:1'b1, e02:IDL, e03:SW_SET | 9'd1, e04:SW_SET, e27:SW_SET,
                e28:SW_ACT0, e29:SW_ACT0, e30:SW_ACT1, e77:SW_ACT1, e78:SW_ACT0, e81:SW_ACT0, e82:IDL};

    // Reset state, during and after reset
    repeat (3) @(negedge clk);
    check("reset_held", outs, IDL);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_released", outs, IDL);

    // Table of single bus cycles
    for (int i = 0; i < 7; i++) begin
      run_seq(100, 25, 75, vecs[i].rw, vecs[i].sram, vecs[i].periph);
      for (int k = 0; k < 11; k++)
        check($sformatf("vec%0d_t%0d", i, samp_t[k]), cap[samp_t[k]], exp_at(vecs[i], k));
    end

    // E stuck high: watchdog aborts once ACTIVE has counted to the limit
    run_seq(340, 25, 325, 1'b1, 1'b1, 1'b0);
    check("tmo_t228", cap[228], SR_ACT);
    check("tmo_t229", cap[229], TMO);
    check("tmo_t230", cap[230], IDL);
    check("tmo_t339", cap[339], IDL);
    cnt = 0;
    for (int t = 0; t < 340; t++) if (cap[t][1]) cnt++;
    check_int("tmo_pulses", cnt, 1);

    // E fall detected on the same cycle the counter reaches the limit: no abort
    run_seq(260, 25, 226, 1'b1, 1'b1, 1'b0);
    check("race_t228", cap[228], SR_ACT);
    check("race_t229", cap[229], SR_ACT);
    check("race_t232", cap[232], SR_ACT);
    check("race_t233", cap[233], IDL);
    cnt = 0;
    for (int t = 0; t < 260; t++) if (cap[t][1]) cnt++;
    check_int("race_pulses", cnt, 0);

    // Next Q rise lands in HOLD: SRAM write followed directly by peripheral read
    for (int t = 0; t < 170; t++) begin
      @(negedge clk);
      cap[t]     = outs;
      q_pin      = (t < 50) || ((t >= 78) && (t < 128));
      e_pin      = ((t >= 25) && (t < 75)) || ((t >= 103) && (t < 153));
      rw         = (t >= 78);
      sel_sram   = (t < 78);
      sel_periph = (t >= 78);
    end
    check("defer_t77", cap[77], SW_ACT1);
    check("defer_t81", cap[81], SW_ACT0);
    check("defer_t82", cap[82], PR_SET);
    check("defer_t106", cap[106], PR_ACT);
    check("defer_t156", cap[156], PR_HLD);
    check("defer_t160", cap[160], IDL);
    cnt = 0;
    for (int t = 3; t < 160; t++) if (!cap[t][2]) cnt++;
    check_int("defer_busy_gaps", cnt, 0);

    // Reset in the middle of an active SRAM write
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      cap[t]     = outs;
      q_pin      = (t < 50);
      e_pin      = (t >= 25) && (t < 75);
      rw         = 1'b0;
      sel_sram   = 1'b1;
      sel_periph = 1'b0;
      if (t == 35) begin
        check("rst_before", cap[35], SW_ACT1);
        #2 rst = 1'b1;
        #1 check("rst_async", outs, IDL);
      end
      if (t == 55) rst = 1'b0;
    end
    cnt = 0;
    for (int t = 36; t < 100; t++) if (cap[t] !== IDL) cnt++;
    check_int("rst_quiet", cnt, 0);

    // Sequencer runs normally again after the mid-cycle reset
    run_seq(100, 25, 75, vecs[0].rw, vecs[0].sram, vecs[0].periph);
    check("recover_t3", cap[3], SR_SET);
    check("recover_t28", cap[28], SR_ACT);
    check("recover_t82", cap[82], IDL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
